// File: rtl/spi_burst_ctrl.sv
// Burst sequencer feeding a single-byte SPI master from a TX FIFO
// and collecting returned bytes into a first-word-fall-through RX FIFO.
module spi_burst_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_wr_en,
  input  logic [7:0]       tx_wr_data,
  output logic             tx_full,
  output logic             tx_ovf,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             rx_rd_en,
  output logic [7:0]       rx_rd_data,
  output logic             rx_empty,
  output logic             burst_done,
  output logic             spi_start,
  output logic [7:0]       spi_tx_data,
  input  logic             spi_busy,
  input  logic             spi_done,
  input  logic [7:0]       spi_rx_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_t;

  state_t state, nxt;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [AW-1:0]    tx_wp, tx_rp;
  logic [CW-1:0]    tx_cnt;
  logic             tx_empty, tx_push, tx_pop;

  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [AW-1:0]    rx_wp, rx_rp;
  logic [CW-1:0]    rx_cnt;
  logic             rx_full, rx_push, rx_pop, rx_wr;

  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic             last;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == DEPTH);
  // Fullness is judged before any same-cycle pop, so a push into a
  // full FIFO is always dropped.
  assign tx_push  = tx_wr_en && !tx_full;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == DEPTH);
  assign rx_push  = rx_wr && !rx_full;
  assign rx_pop   = rx_rd_en && !rx_empty;
  assign rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];

  assign cmd_ready = (state == IDLE);
  assign spi_start = (state == START);
  assign last      = (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_wr_data;
    if (rx_push) rx_mem[rx_wp] <= spi_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_wr_en && tx_full) tx_ovf <= 1'b1;
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    tx_pop = 1'b0;
    rx_wr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len != '0) nxt = LOAD;
        end
      end
      // Checking RX space here keeps at most one byte in flight
      // and makes RX overflow impossible.
      LOAD: begin
        if (!tx_empty && !rx_full && !spi_busy) begin
          tx_pop = 1'b1;
          nxt    = START;
        end
      end
      START: nxt = WAIT;
      WAIT: begin
        if (spi_done) begin
          rx_wr = 1'b1;
          nxt   = last ? IDLE : LOAD;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      spi_tx_data <= 8'h00;
      burst_done  <= 1'b0;
    end else begin
      if (accept)     remaining <= cmd_len;
      else if (rx_wr) remaining <= remaining - LEN_W'(1);
      if (tx_pop) spi_tx_data <= tx_mem[tx_rp];
      burst_done <= (accept && (cmd_len == '0)) || (rx_wr && last);
    end
  end

endmodule

// File: doc/spi_burst_ctrl.md
SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX and RX FIFO depth in bytes (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 4, width of burst length field.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx_wr_en  input  1  push tx_wr_data into TX FIFO.
REQ-006 tx_wr_data  input  8  byte to transmit.
REQ-007 tx_full  output  1  TX FIFO full.
REQ-008 tx_ovf  output  1  sticky: push attempted while TX FIFO full.
REQ-009 cmd_valid  input  1  burst request.
REQ-010 cmd_len  input  LEN_W  bytes in burst (0..2^LEN_W-1).
REQ-011 cmd_ready  output  1  burst request accepted when high with cmd_valid.
REQ-012 rx_rd_en  input  1  pop RX FIFO head.
REQ-013 rx_rd_data  output  8  RX FIFO head, first-word-fall-through.
REQ-014 rx_empty  output  1  RX FIFO empty.
REQ-015 burst_done  output  1  one-cycle pulse at burst completion.
REQ-016 spi_start  output  1  start pulse to SPI byte master.
REQ-017 spi_tx_data  output  8  byte for SPI byte master.
REQ-018 spi_busy  input  1  SPI byte master busy.
REQ-019 spi_done  input  1  one-cycle pulse, byte transfer complete.
REQ-020 spi_rx_data  input  8  received byte, valid in spi_done cycle.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, START, WAIT.
REQ-022 cmd_ready SHALL equal (state==IDLE); accept = cmd_valid && cmd_ready; on accept latch remaining=cmd_len, go LOAD.
REQ-023 Accept with cmd_len=0: no SPI traffic, burst_done high next cycle, stay IDLE.
REQ-024 LOAD->START when TX not empty, RX not full, spi_busy low; same edge pops TX head into spi_tx_data register; otherwise hold LOAD indefinitely.
REQ-025 spi_start SHALL be high exactly one cycle, in START only; START->WAIT unconditionally.
REQ-026 spi_tx_data SHALL hold stable from START until the matching spi_done.
REQ-027 WAIT on spi_done: push spi_rx_data into RX FIFO, remaining-=1; remaining reaching 0 -> IDLE with burst_done high next cycle, else -> LOAD.
REQ-028 Latency: accept at cycle N with data present -> spi_start at N+2; next spi_start 2 cycles after each spi_done.
REQ-029 At most one byte in flight; RX space checked in LOAD, so RX overflow SHALL be impossible.
REQ-030 spi_done outside WAIT SHALL be ignored (no push, no state change).
REQ-031 TX push when full: data dropped, tx_ovf set, cleared only by rst; push+internal pop same cycle when full: pop happens, push dropped.
REQ-032 rx_rd_en when empty SHALL be ignored; push and pop in same cycle SHALL both take effect, count unchanged.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty via count of width log2(FIFO_DEPTH)+1.
REQ-034 TX FIFO accepts pushes in any state, including mid-burst.

Reset
REQ-035 rst asserted SHALL immediately force: state IDLE, spi_start 0, spi_tx_data 0x00, burst_done 0, tx_ovf 0, both FIFOs empty (tx_full 0, rx_empty 1), rx_rd_data 0x00, remaining 0, cmd_ready 1 after deassertion.
REQ-036 Reset mid-burst SHALL discard the burst; late spi_done after reset is ignored per REQ-030.

Verification
REQ-037 Push 0xA5,0x3C; cmd_len=2; model echoes MOSI -> two spi_start pulses, RX holds 0xA5,0x3C, one burst_done.
REQ-038 cmd_len=3 with TX empty -> FSM holds LOAD, no spi_start; push 3 bytes -> 3 transfers, burst_done once.
REQ-039 Fill RX to 8 with no reads, issue cmd_len=1 -> no spi_start until one rx_rd_en, then transfer proceeds.
REQ-040 Push 9 bytes with FIFO_DEPTH=8 -> tx_full after 8th, tx_ovf=1, 9th byte never transmitted.
REQ-041 cmd_len=0 -> burst_done at N+1, spi_start never high.
REQ-042 Assert rst during WAIT of burst len 4 -> outputs at reset values, late spi_done ignored, rx_empty stays 1.
